// File: rtl/coin_pkg.sv
// Shared constants and helpers for the coin input conditioner: coin widths,
// button count and the button-index to coin-value mapping.
package coin_pkg;

  localparam int unsigned COIN_W    = 3;
  localparam int unsigned NUM_COINS = 4;
  localparam int unsigned IDX_W     = 2;

  typedef logic [COIN_W-1:0] coin_t;
  typedef logic [IDX_W-1:0]  coin_idx_t;

  localparam coin_t COIN_V0 = 3'd1;
  localparam coin_t COIN_V1 = 3'd2;
  localparam coin_t COIN_V2 = 3'd3;
  localparam coin_t COIN_V3 = 3'd5;

  // Arbiter decision for one cycle: which pending button is moved into the buffer.
  typedef struct packed {
    logic      push;
    coin_idx_t idx;
  } coin_grant_t;

  function automatic coin_t coin_value_of(input coin_idx_t idx);
    coin_t val;
    case (idx)
      2'd0:    val = COIN_V0;
      2'd1:    val = COIN_V1;
      2'd2:    val = COIN_V2;
      default: val = COIN_V3;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One button: two-flop synchroniser, consecutive-sample debounce counter and
// stable level; press_c flags the stable 1->0 transition on the edge it happens.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button_n,
  output logic press_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      sync1 <= button_n;
      sync2 <= sync1;
      // Any sample that agrees with the stable level restarts qualification.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press_c = stable && !sync2 && (cnt == CNT_LAST);

endmodule

// File: rtl/coin_input_conditioner.sv
// Turns four raw active-low coin buttons into a valid/ready stream of coin tokens.
// Build option COIN_QUEUE_EN: FIFO_DEPTH-entry token FIFO; otherwise a single output register.
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_COINS-1:0] button_n,
  output logic                 coin_valid,
  output logic [COIN_W-1:0]    coin_value,
  input  logic                 coin_ready,
  output logic                 coin_drop
);

  if (DEBOUNCE_CYCLES < 2 || (DEBOUNCE_CYCLES >> CNT_W) != 0 || FIFO_DEPTH == 0) begin : g_param_err
    $error("coin_input_conditioner: illegal DEBOUNCE_CYCLES/CNT_W/FIFO_DEPTH");
  end

  logic [NUM_COINS-1:0] press_c;
  logic [NUM_COINS-1:0] pending;
  logic [NUM_COINS-1:0] clear_c;
  coin_grant_t          grant_c;
  coin_t                push_value_c;
  logic                 pop_c;
  logic                 full_c;

  for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_deb
    coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .button_n(button_n[gi]),
      .press_c (press_c[gi])
    );
  end

  // Lowest-index pending button wins; a pop in the same cycle frees a full buffer.
  always_comb begin
    logic found;
    found        = 1'b0;
    grant_c      = '0;
    clear_c      = '0;
    pop_c        = coin_valid && coin_ready;
    for (int i = 0; i < int'(NUM_COINS); i++) begin
      if (pending[i] && !found) begin
        found       = 1'b1;
        grant_c.idx = IDX_W'(i);
      end
    end
    grant_c.push = found && (!full_c || pop_c);
    if (grant_c.push) begin
      clear_c[grant_c.idx] = 1'b1;
    end
    push_value_c = coin_value_of(grant_c.idx);
  end

  // A press on a bit that is still pending (and not leaving this cycle) is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      coin_drop <= 1'b0;
    end else begin
      pending   <= (pending & ~clear_c) | press_c;
      coin_drop <= |(press_c & pending & ~clear_c);
    end
  end

`ifdef COIN_QUEUE_EN

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_err
    $error("coin_input_conditioner: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  coin_t          mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;

  assign full_c = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (grant_c.push) begin
        mem[wr_ptr[PTR_W-1:0]] <= push_value_c;
        wr_ptr                 <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

  assign coin_valid = (wr_ptr != rd_ptr);
  assign coin_value = mem[rd_ptr[PTR_W-1:0]];

`else

  logic  valid_q;
  coin_t value_q;

  assign full_c = valid_q;

  // Single output slot; the value only changes when a new token is loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      value_q <= '0;
    end else if (grant_c.push) begin
      valid_q <= 1'b1;
      value_q <= push_value_c;
    end else if (pop_c) begin
      valid_q <= 1'b0;
    end
  end

  assign coin_valid = valid_q;
  assign coin_value = value_q;

`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Randomised and directed bench for coin_input_conditioner against a
// behavioural token model (windowed debounce, pending bits, token queue).
module tb_coin_input_conditioner;

  localparam int unsigned N    = 4;
  localparam logic [31:0] MASK = (32'd1 << N) - 32'd1;
`ifdef COIN_QUEUE_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] button_n = 4'hF;
  logic       coin_ready = 1'b0;
  logic       coin_valid;
  logic [2:0] coin_value;
  logic       coin_drop;

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (16),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .button_n  (button_n),
    .coin_valid(coin_valid),
    .coin_value(coin_value),
    .coin_ready(coin_ready),
    .coin_drop (coin_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drops = 0;
  int tok_val[$];
  int tok_cyc[$];
  int vals[4] = '{1, 2, 3, 5};

  // Reference model state
  int          m_q[$];
  logic [3:0]  m_pending;
  logic [3:0]  m_stable;
  logic        m_drop;
  logic [31:0] m_hist[4];
  logic [1:0]  m_dly[4];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pending = '0;
    m_stable  = '1;
    m_drop    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = '1;
      m_dly[i]  = 2'b11;
    end
  endtask

  // A stable level flips once the last N synchronised samples all disagree with it.
  task automatic model_step();
    logic [3:0]  press;
    logic [3:0]  clear;
    logic [31:0] window;
    logic        v;
    bit          pop;
    bit          can_push;
    int          sel;
    if (reset) begin
      model_reset();
      return;
    end
    press = '0;
    clear = '0;
    pop = (m_q.size() > 0) && coin_ready;
    for (int i = 0; i < 4; i++) begin
      v         = m_dly[i][1];
      m_dly[i]  = {m_dly[i][0], button_n[i]};
      m_hist[i] = {m_hist[i][30:0], v};
      window    = m_hist[i] & MASK;
      if (m_stable[i] && window == 32'd0) begin
        m_stable[i] = 1'b0;
        press[i]    = 1'b1;
      end else if (!m_stable[i] && window == MASK) begin
        m_stable[i] = 1'b1;
      end
    end
    can_push = (m_q.size() < DEPTH) || pop;
    sel = -1;
    for (int i = 0; i < 4; i++) begin
      if (m_pending[i] && sel < 0) sel = i;
    end
    if (sel >= 0 && can_push) clear[sel] = 1'b1;
    m_drop    = |(press & m_pending & ~clear);
    m_pending = (m_pending & ~clear) | press;
    if (pop) void'(m_q.pop_front());
    if (clear != 4'd0) m_q.push_back(vals[sel]);
  endtask

  task automatic tick();
    if (coin_valid && coin_ready && !reset) begin
      tok_val.push_back(int'(coin_value));
      tok_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check_eq("valid", int'(coin_valid), int'(m_q.size() > 0));
    check_eq("drop", int'(coin_drop), int'(m_drop));
    if (m_q.size() > 0) check_eq("value", int'(coin_value), m_q[0]);
    if (coin_drop) drops++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic ticks_to_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!coin_valid && n < 50);
  endtask

  task automatic press_btn(input int idx, input int low, input int high);
    button_n[idx] = 1'b0;
    ticks(low);
    button_n[idx] = 1'b1;
    ticks(high);
  endtask

  task automatic check_tokens(input string tag, input int exp[$]);
    check_eq({tag, "_count"}, tok_val.size(), exp.size());
    for (int k = 0; k < exp.size() && k < tok_val.size(); k++)
      check_eq(tag, tok_val[k], exp[k]);
  endtask

  initial begin
    int n;
    int d0;
    int exp_q[$];

    // Reset state
    reset = 1'b1;
    ticks(3);
    check_eq("rst_valid", int'(coin_valid), 0);
    check_eq("rst_value", int'(coin_value), 0);
    check_eq("rst_drop", int'(coin_drop), 0);
    reset = 1'b0;
    ticks(2);

    // Clean press of button1
    coin_ready = 1'b1;
    tok_val.delete();
    button_n[1] = 1'b0;
    ticks_to_valid(n);
    check_eq("clean_latency", n, 7);
    ticks(3);
    button_n[1] = 1'b1;
    ticks(15);
    exp_q = '{2};
    check_tokens("clean_tok", exp_q);

    // Bouncy press of button3
    tok_val.delete();
    button_n[3] = 1'b0;
    ticks(3);
    button_n[3] = 1'b1;
    tick();
    button_n[3] = 1'b0;
    ticks_to_valid(n);
    check_eq("bounce_latency", n, 7);
    ticks(8);
    button_n[3] = 1'b1;
    ticks(15);
    exp_q = '{5};
    check_tokens("bounce_tok", exp_q);

    // All four buttons on the same edge
    tok_val.delete();
    tok_cyc.delete();
    button_n = 4'h0;
    ticks(10);
    button_n = 4'hF;
    ticks(15);
    exp_q = '{1, 2, 3, 5};
    check_tokens("burst_tok", exp_q);
    for (int k = 1; k < tok_cyc.size(); k++)
      check_eq("burst_gap", tok_cyc[k] - tok_cyc[k-1], 1);

    // Back-pressure: five presses with coin_ready low, then a dropped sixth
    coin_ready = 1'b0;
    tok_val.delete();
    d0 = drops;
    press_btn(0, 8, 12);
    press_btn(1, 8, 12);
    press_btn(2, 8, 12);
    press_btn(3, 8, 12);
    press_btn(0, 8, 12);
    check_eq("hold_valid", int'(coin_valid), 1);
    check_eq("hold_head", int'(coin_value), 1);
    check_eq("hold_nodrop", drops - d0, 0);
    press_btn(0, 8, 12);
    check_eq("hold_drop", drops - d0, 1);
    coin_ready = 1'b1;
    ticks(12);
`ifdef COIN_QUEUE_EN
    exp_q = '{1, 2, 3, 5, 1};
`else
    exp_q = '{1, 1, 2, 3, 5};
`endif
    check_tokens("drain_tok", exp_q);

    // Reset with tokens buffered and debounces in progress
    coin_ready = 1'b0;
    press_btn(0, 8, 4);
    press_btn(1, 8, 4);
    check_eq("pre_rst_valid", int'(coin_valid), 1);
    button_n[2] = 1'b0;
    button_n[3] = 1'b0;
    ticks(3);
    button_n[2] = 1'b1;
    reset = 1'b1;
    tick();
    check_eq("mid_rst_valid", int'(coin_valid), 0);
    tick();
    reset = 1'b0;
    coin_ready = 1'b1;
    tok_val.delete();
    ticks(12);
    button_n[3] = 1'b1;
    ticks(15);
    exp_q = '{5};
    check_tokens("rst_tok", exp_q);

    // Random presses, bounces, back-pressure and occasional reset
    for (int k = 0; k < 1500; k++) begin
`ifdef COIN_QUEUE_EN
      coin_ready = ($urandom_range(0, 3) != 0);
`else
      coin_ready = ~coin_ready;
`endif
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 29) == 0) button_n[b] = ~button_n[b];
      reset = ($urandom_range(0, 699) == 0);
      tick();
    end
    reset = 1'b0;
    button_n = 4'hF;
    coin_ready = 1'b1;
    ticks(40);
    check_eq("final_empty", int'(coin_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
